cms_trace_ctrl: RTL and testbench
=================================

# cms_trace_ctrl

Configuration and sequencing controller for the continuous monitoring system. It decodes host register writes and reads on the 16-entry internal address space, holds the trace configuration, and runs the arm/trigger/stop state machine. While the monitor is running, it filters the committed-PC stream into trace events and counts them.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, register and PC width
- AXI_ADDR_WIDTH, 4, internal word address width (16 addresses)

Ports:
- clk  in  1  system clock; one clock domain only
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  host write strobe; accepted every cycle, no backpressure
- wr_addr  in  AXI_ADDR_WIDTH  write word address
- wr_data  in  AXI_DATA_WIDTH  write data
- rd_en  in  1  host read strobe
- rd_addr  in  AXI_ADDR_WIDTH  read word address
- rd_data  out  AXI_DATA_WIDTH  read data, valid the cycle after rd_en
- pc_valid  in  1  committed-instruction strobe from the core
- pc  in  AXI_DATA_WIDTH  committed PC
- trace_valid  out  1  filtered trace event
- trace_pc  out  AXI_DATA_WIDTH  PC of the trace event
- state  out  2  IDLE=0, ARMED=1, RUNNING=2, STOPPED=3
- done_pulse  out  1  one-cycle pulse on entry to STOPPED

## Operation
Address map (word index):
- 0 CTRL (write-only, self-clearing): bit0 ARM, bit1 HALT. Reads return 0.
- 1 TRIGGER_PC
- 2 STOP_PC
- 3 RANGE_LO
- 4 RANGE_HI
- 5 LIMIT (0 = unlimited)
- 6 STATUS (read-only): bits[1:0] = state
- 7 COUNT (read-only)
- 8–15: writes ignored, reads return 0.

Configuration registers:
- Reset values: TRIGGER_PC=0, STOP_PC=0, RANGE_LO=0, RANGE_HI=all-ones, LIMIT=0, COUNT=0.
- Writes to addresses 1–5 take effect only in IDLE or STOPPED. In ARMED or RUNNING they are silently dropped.

Hit definition:
- A hit is pc_valid && RANGE_LO <= pc <= RANGE_HI (unsigned, inclusive). If RANGE_LO > RANGE_HI, no hits occur.

State transitions:
- IDLE/STOPPED → ARMED on ARM. Clears COUNT.
- ARMED → RUNNING on pc_valid && pc==TRIGGER_PC. The trigger instruction itself is traced if it is a hit. STOP_PC and LIMIT are not evaluated in this cycle.
- RUNNING → STOPPED on any of:
  - pc_valid && pc==STOP_PC (the stop instruction is traced if it is a hit);
  - a hit when COUNT+1 == LIMIT and LIMIT != 0 (that hit is traced).
- ARMED/RUNNING → STOPPED on HALT.

Priority and corner cases:
- HALT beats ARM when both are in the same write, and beats any same-cycle PC event.
- A HALT in the same cycle as a hit suppresses that trace event.
- ARM while in ARMED or RUNNING is ignored.
- HALT while in IDLE or STOPPED is ignored.
- Each traced hit increments COUNT. COUNT saturates at all-ones.
- LIMIT=1: the first hit after the trigger is traced, then the block stops.

## Timing
- Reset: all outputs are 0 (state=IDLE, rd_data=0, trace_valid=0, trace_pc=0, done_pulse=0). Config registers take their reset values. A reset asserted mid-run aborts to IDLE with no done_pulse.
- A write in cycle N is visible to reads and to the FSM from cycle N+1.
- Read: rd_en in cycle N → rd_data in N+1, holding the register value as of cycle N. A read and a write to the same address in the same cycle return the old value. rd_data holds its value while rd_en is low.
- Trace: a hit in cycle N → trace_valid/trace_pc in N+1; trace_valid is low otherwise.
- state updates in N+1. done_pulse is high in the first cycle that state==STOPPED.
- COUNT read in N+1 includes the hit from cycle N.

## Structure
- Package cms_pkg holds:
  - address map localparams;
  - the state enum encoding;
  - CTRL bit positions;
  - reset values of the config registers.
- Sub-module cms_trace_filter: range compare plus registered trace_valid/trace_pc, with a suppress input driven by HALT.
- The top level holds the register file, the read mux and the FSM.

## Test plan
- Reset, then read addresses 0–15: RANGE_HI=0xFFFFFFFF, every other address reads 0; all outputs are 0.
- TRIGGER_PC=0x100, STOP_PC=0x120, full range, ARM; stream pc 0xF0..0x130 in steps of 4 with pc_valid=1 → trace 0x100..0x120 (9 events), COUNT=9, state=STOPPED, done_pulse asserted once.
- LIMIT=3, RANGE 0x200–0x2FF, trigger 0x100; stream pc 0x100, 0x104, 0x200, 0x204, 0x300, 0x208, 0x20C → traces 0x200, 0x204, 0x208, then STOPPED; 0x20C is not traced.
- While RUNNING, write RANGE_LO=0x5 → read-back unchanged. Then HALT in the same cycle as a hit → no trace event, STOPPED; a new RANGE_LO write now succeeds.
- Write CTRL=0x3 from IDLE → state stays IDLE (HALT wins over ARM, and HALT in IDLE is ignored).
- Reset asserted while RUNNING → next cycle state=IDLE, COUNT=0, trace_valid=0, no done_pulse.

Source files
------------

// File: rtl/cms_pkg.sv
// Shared definitions for the continuous-monitoring trace controller:
// address map, state encoding, CTRL bit positions and register reset values.
package cms_pkg;

   localparam int ADDR_CTRL     = 0;
   localparam int ADDR_TRIGGER  = 1;
   localparam int ADDR_STOP     = 2;
   localparam int ADDR_RANGE_LO = 3;
   localparam int ADDR_RANGE_HI = 4;
   localparam int ADDR_LIMIT    = 5;
   localparam int ADDR_STATUS   = 6;
   localparam int ADDR_COUNT    = 7;

   localparam int CTRL_ARM_BIT  = 0;
   localparam int CTRL_HALT_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_STOPPED = 2'd3
   } cms_state_e;

   localparam logic [31:0] RST_TRIGGER_PC = 32'h0000_0000;
   localparam logic [31:0] RST_STOP_PC    = 32'h0000_0000;
   localparam logic [31:0] RST_RANGE_LO   = 32'h0000_0000;
   localparam logic [31:0] RST_RANGE_HI   = 32'hFFFF_FFFF;
   localparam logic [31:0] RST_LIMIT      = 32'h0000_0000;

endpackage

// File: rtl/cms_trace_filter.sv
// Inclusive unsigned range compare on the committed-PC stream with a
// registered trace output; suppress kills an event in the cycle it occurs.
module cms_trace_filter #(
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pc_valid,
   input  logic [AXI_DATA_WIDTH-1:0] pc,
   input  logic [AXI_DATA_WIDTH-1:0] range_lo,
   input  logic [AXI_DATA_WIDTH-1:0] range_hi,
   input  logic                      enable,
   input  logic                      suppress,
   output logic                      fire,
   output logic                      trace_valid,
   output logic [AXI_DATA_WIDTH-1:0] trace_pc
);

   logic hit;

   // An inverted range (lo > hi) can never satisfy both bounds, so no hits.
   assign hit  = pc_valid && (pc >= range_lo) && (pc <= range_hi);
   assign fire = enable && hit && !suppress;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trace_valid <= 1'b0;
         trace_pc    <= '0;
      end else begin
         trace_valid <= fire;
         if (fire) trace_pc <= pc;
      end
   end

endmodule

// File: rtl/cms_trace_ctrl.sv
// Trace controller top: host register file and read mux, arm/trigger/stop
// state machine, and the traced-hit counter.
module cms_trace_ctrl
   import cms_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   input  logic                      rd_en,
   input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   input  logic                      pc_valid,
   input  logic [AXI_DATA_WIDTH-1:0] pc,
   output logic                      trace_valid,
   output logic [AXI_DATA_WIDTH-1:0] trace_pc,
   output logic [1:0]                state,
   output logic                      done_pulse
);

   localparam int W = AXI_DATA_WIDTH;

   cms_state_e state_q, state_d;

   logic [W-1:0] trigger_q, stop_q, range_lo_q, range_hi_q, limit_q, count_q;
   logic [W-1:0] rd_mux;

   logic ctrl_wr, arm_req, halt_req, cfg_wr_ok, arm_go;
   logic trigger_match, stop_match, trace_en, fire, limit_hit;

   assign ctrl_wr  = wr_en && (int'(wr_addr) == ADDR_CTRL);
   assign arm_req  = ctrl_wr && wr_data[CTRL_ARM_BIT];
   assign halt_req = ctrl_wr && wr_data[CTRL_HALT_BIT];

   // Configuration is frozen while a capture is armed or in progress.
   assign cfg_wr_ok = (state_q == ST_IDLE) || (state_q == ST_STOPPED);

   assign trigger_match = pc_valid && (pc == trigger_q);
   assign stop_match    = pc_valid && (pc == stop_q);
   assign trace_en      = ((state_q == ST_ARMED) && trigger_match) ||
                          (state_q == ST_RUNNING);

   cms_trace_filter #(.AXI_DATA_WIDTH(W)) u_filter (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .range_lo    (range_lo_q),
      .range_hi    (range_hi_q),
      .enable      (trace_en),
      .suppress    (halt_req),
      .fire        (fire),
      .trace_valid (trace_valid),
      .trace_pc    (trace_pc)
   );

   assign limit_hit = fire && (limit_q != '0) && ((count_q + W'(1)) == limit_q);

   always_comb begin
      state_d = state_q;
      arm_go  = 1'b0;
      case (state_q)
         ST_IDLE, ST_STOPPED: begin
            if (arm_req && !halt_req) begin
               state_d = ST_ARMED;
               arm_go  = 1'b1;
            end
         end
         ST_ARMED: begin
            if (halt_req)           state_d = ST_STOPPED;
            else if (trigger_match) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (halt_req || stop_match || limit_hit) state_d = ST_STOPPED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         done_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_pulse <= (state_q != ST_STOPPED) && (state_d == ST_STOPPED);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trigger_q  <= W'(RST_TRIGGER_PC);
         stop_q     <= W'(RST_STOP_PC);
         range_lo_q <= W'(RST_RANGE_LO);
         range_hi_q <= W'(RST_RANGE_HI);
         limit_q    <= W'(RST_LIMIT);
      end else if (wr_en && cfg_wr_ok) begin
         case (int'(wr_addr))
            ADDR_TRIGGER:  trigger_q  <= wr_data;
            ADDR_STOP:     stop_q     <= wr_data;
            ADDR_RANGE_LO: range_lo_q <= wr_data;
            ADDR_RANGE_HI: range_hi_q <= wr_data;
            ADDR_LIMIT:    limit_q    <= wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                          count_q <= '0;
      else if (arm_go)                     count_q <= '0;
      else if (fire && (count_q != '1))    count_q <= count_q + W'(1);
   end

   always_comb begin
      rd_mux = '0;
      case (int'(rd_addr))
         ADDR_TRIGGER:  rd_mux = trigger_q;
         ADDR_STOP:     rd_mux = stop_q;
         ADDR_RANGE_LO: rd_mux = range_lo_q;
         ADDR_RANGE_HI: rd_mux = range_hi_q;
         ADDR_LIMIT:    rd_mux = limit_q;
         ADDR_STATUS:   rd_mux = W'(state_q);
         ADDR_COUNT:    rd_mux = count_q;
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= rd_mux;
   end

   assign state = state_q;

endmodule

// File: tb/tb_cms_trace_ctrl.sv
// Directed bench for cms_trace_ctrl: register-map table, trace streams,
// frozen-config, HALT priority and mid-run reset sequences.
module tb_cms_trace_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          pc_valid;
   logic [DW-1:0] pc;
   logic          trace_valid;
   logic [DW-1:0] trace_pc;
   logic [1:0]    state;
   logic          done_pulse;

   cms_trace_ctrl #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .trace_valid (trace_valid),
      .trace_pc    (trace_pc),
      .state       (state),
      .done_pulse  (done_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
   } rd_vec_t;

   rd_vec_t       rv [16];
   logic [DW-1:0] exp_q [$];
   int            n_vec  = 0;
   int            n_err  = 0;
   int            n_done = 0;
   logic [DW-1:0] rv_data;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   // One clock, then scoreboard any trace event and count done pulses.
   task automatic cycle();
      logic [DW-1:0] e;
      @(posedge clk);
      #1;
      if (trace_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL trace_unexpected: got pc 0x%08h, required no event", trace_pc);
         end else begin
            e = exp_q.pop_front();
            chk("trace_pc", trace_pc, e);
         end
      end
      if (done_pulse) n_done++;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int a, output logic [DW-1:0] d);
      rd_en = 1'b1; rd_addr = AW'(a);
      cycle();
      d = rd_data;
      rd_en = 1'b0;
   endtask

   task automatic pcs(input logic [DW-1:0] p);
      pc_valid = 1'b1; pc = p;
      cycle();
      pc_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0; pc_valid = 1'b0; pc = '0;

      for (int i = 0; i < 16; i++) begin
         rv[i].addr = AW'(i);
         rv[i].exp  = (i == 4) ? 32'hFFFF_FFFF : 32'h0;
      end

      // Reset state
      cycle(); cycle();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_trace_valid", 32'(trace_valid), 32'd0);
      chk("rst_trace_pc", trace_pc, 32'h0);
      chk("rst_done", 32'(done_pulse), 32'd0);
      rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 16; i++) begin
         rd(int'(rv[i].addr), rv_data);
         chk($sformatf("rst_read_%0d", i), rv_data, rv[i].exp);
      end

      // Trigger/stop stream over full range
      wr(1, 32'h100);
      wr(2, 32'h120);
      wr(0, 32'h1);
      chk("armed_state", 32'(state), 32'd1);
      n_done = 0;
      for (int p = 32'hF0; p <= 32'h100 - 4; p += 4) pcs(DW'(p));
      for (int p = 32'h100; p <= 32'h120; p += 4) exp_q.push_back(DW'(p));
      for (int p = 32'h100; p <= 32'h130; p += 4) pcs(DW'(p));
      cycle();
      chk("s1_queue_left", 32'(exp_q.size()), 32'd0);
      chk("s1_state", 32'(state), 32'd3);
      chk("s1_done_count", 32'(n_done), 32'd1);
      rd(7, rv_data);
      chk("s1_count", rv_data, 32'd9);
      rd(6, rv_data);
      chk("s1_status", rv_data, 32'd3);

      // LIMIT=3 with narrow range
      wr(5, 32'd3);
      wr(3, 32'h200);
      wr(4, 32'h2FF);
      wr(0, 32'h1);
      n_done = 0;
      exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
      pcs(32'h100); pcs(32'h104); pcs(32'h200); pcs(32'h204);
      pcs(32'h300); pcs(32'h208);
      chk("s2_state_at_limit", 32'(state), 32'd3);
      chk("s2_done_at_limit", 32'(done_pulse), 32'd1);
      pcs(32'h20C);
      cycle();
      chk("s2_queue_left", 32'(exp_q.size()), 32'd0);
      chk("s2_done_count", 32'(n_done), 32'd1);
      rd(7, rv_data);
      chk("s2_count", rv_data, 32'd3);

      // Config frozen while RUNNING, then HALT with a same-cycle hit
      wr(5, 32'd0);
      wr(3, 32'h0);
      wr(4, 32'hFFFF_FFFF);
      wr(0, 32'h1);
      n_done = 0;
      exp_q.push_back(32'h100);
      pcs(32'h100);
      chk("s3_running", 32'(state), 32'd2);
      wr(3, 32'h5);
      rd(3, rv_data);
      chk("s3_frozen_lo", rv_data, 32'h0);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h2;
      pc_valid = 1'b1; pc = 32'h104;
      cycle();
      wr_en = 1'b0; pc_valid = 1'b0;
      chk("s3_halt_trace", 32'(trace_valid), 32'd0);
      chk("s3_halt_state", 32'(state), 32'd3);
      chk("s3_halt_done", 32'(done_pulse), 32'd1);
      rd(7, rv_data);
      chk("s3_count", rv_data, 32'd1);
      wr(3, 32'h5);
      rd(3, rv_data);
      chk("s3_lo_written", rv_data, 32'h5);
      chk("s3_queue_left", 32'(exp_q.size()), 32'd0);

      // Reset while RUNNING aborts to IDLE without done_pulse
      wr(0, 32'h1);
      exp_q.push_back(32'h100);
      pcs(32'h100);
      chk("s4_running", 32'(state), 32'd2);
      n_done = 0;
      rst_n = 1'b0; pc_valid = 1'b1; pc = 32'h104;
      cycle();
      rst_n = 1'b1; pc_valid = 1'b0;
      chk("s4_rst_state", 32'(state), 32'd0);
      chk("s4_rst_trace", 32'(trace_valid), 32'd0);
      chk("s4_rst_done", 32'(done_pulse), 32'd0);
      rd(7, rv_data);
      chk("s4_rst_count", rv_data, 32'd0);
      chk("s4_done_count", 32'(n_done), 32'd0);
      chk("s4_queue_left", 32'(exp_q.size()), 32'd0);

      // CTRL=3 from IDLE: HALT wins over ARM and is itself ignored
      wr(0, 32'h3);
      chk("s5_ctrl3_state", 32'(state), 32'd0);
      cycle();
      chk("s5_ctrl3_state_late", 32'(state), 32'd0);
      chk("s5_ctrl3_done", 32'(n_done), 32'd0);
      rd(0, rv_data);
      chk("s5_ctrl_reads_zero", rv_data, 32'h0);

      // Same-cycle read and write return the old value; rd_data then holds
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h55;
      rd_en = 1'b1; rd_addr = 4'd1;
      cycle();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("s6_rw_old", rd_data, 32'h0);
      cycle();
      chk("s6_rd_hold", rd_data, 32'h0);
      rd(1, rv_data);
      chk("s6_rw_new", rv_data, 32'h55);

      // Inverted range produces no trace events
      wr(1, 32'h100);
      wr(3, 32'h300);
      wr(4, 32'h200);
      wr(0, 32'h1);
      pcs(32'h100); pcs(32'h250); pcs(32'h300);
      cycle();
      chk("s7_inv_state", 32'(state), 32'd2);
      rd(7, rv_data);
      chk("s7_inv_count", rv_data, 32'd0);
      wr(0, 32'h2);
      chk("s7_halt_state", 32'(state), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
